// File: rtl/bus_cycle_master_if.sv
// rtl/bus_cycle_master_if.sv - core request/response and multiplexed peripheral bus signal bundle
interface bus_cycle_master_if;
  // core request port
  logic        req;
  logic        req_we;
  logic        req_io;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        req_ready;
  // core response port
  logic        rsp_valid;
  logic        rsp_err;
  logic [7:0]  rsp_rdata;
  // external multiplexed bus
  logic        ALE;
  logic        rdb;
  logic        wrb;
  logic        IOM;
  logic [7:0]  a_hi;
  logic [7:0]  ad_out;
  logic        ad_oe;
  logic [7:0]  ad_in;
  logic        READY;

  // the bus cycle initiator
  modport master (
    input  req, req_we, req_io, req_addr, req_wdata, ad_in, READY,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           ALE, rdb, wrb, IOM, a_hi, ad_out, ad_oe
  );

  // the core plus the peripheral side of the bus
  modport slave (
    output req, req_we, req_io, req_addr, req_wdata, ad_in, READY,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           ALE, rdb, wrb, IOM, a_hi, ad_out, ad_oe
  );
endinterface

// File: rtl/bus_cycle_master.sv
// rtl/bus_cycle_master.sv - T1-T2-(TW)-T3-TURN initiator for the ALE/RD/WR/IO-M bus
module bus_cycle_master #(
  parameter int MAX_WAIT = 15
) (
  input  logic               clock,
  input  logic               reset,
  bus_cycle_master_if.master bus
);

  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  typedef enum logic [5:0] {
    IDLE = 6'b000001,
    T1   = 6'b000010,
    T2   = 6'b000100,
    TW   = 6'b001000,
    T3   = 6'b010000,
    TURN = 6'b100000
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  wait_cnt;
  logic [7:0]  wait_cnt_next;
  logic        timeout_next;
  logic        accept;

  logic        we_q;
  logic        io_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        err_q;
  logic [7:0]  rdata_q;

  logic        in_addr_phase;
  logic        in_strobe_phase;

  assign accept = (state == IDLE) && bus.req;

  // next-state and wait-state counting; a timeout leaves TW straight for TURN
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    timeout_next  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req) begin
          state_next    = T1;
          wait_cnt_next = 8'd0;
        end
      end
      T1: state_next = T2;
      T2: begin
        if (bus.READY) begin
          state_next = T3;
        end else begin
          state_next    = TW;
          wait_cnt_next = 8'd1;
        end
      end
      TW: begin
        if (bus.READY) begin
          state_next = T3;
        end else if (wait_cnt < MAX_W) begin
          wait_cnt_next = wait_cnt + 8'd1;
        end else begin
          state_next   = TURN;
          timeout_next = 1'b1;
        end
      end
      T3:      state_next = TURN;
      TURN:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // state register and wait counter; reset abandons any cycle in flight
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // latch the request at the accept edge so the core may change its fields afterwards
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      io_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
    end else if (accept) begin
      we_q    <= bus.req_we;
      io_q    <= bus.req_io;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // response capture: read data sampled leaving T3, zeroed on writes and timeouts
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      if (accept) begin
        err_q <= 1'b0;
      end else if (timeout_next) begin
        err_q <= 1'b1;
      end
      if (state == T3) begin
        rdata_q <= we_q ? 8'h00 : bus.ad_in;
      end else if (timeout_next) begin
        rdata_q <= 8'h00;
      end
    end
  end

  assign in_addr_phase   = (state == T1) || (state == T2) || (state == TW) || (state == T3);
  assign in_strobe_phase = (state == T2) || (state == TW) || (state == T3);

  // Moore output decode from state and the latched request
  always_comb begin
    bus.req_ready = (state == IDLE);
    bus.rsp_valid = (state == TURN);
    bus.rsp_err   = (state == TURN) && err_q;
    bus.rsp_rdata = rdata_q;
    bus.ALE       = (state == T1);
    bus.rdb       = !(in_strobe_phase && !we_q);
    bus.wrb       = !(in_strobe_phase && we_q);
    bus.IOM       = in_addr_phase && io_q;
    bus.a_hi      = in_addr_phase ? addr_q[15:8] : 8'h00;
    bus.ad_out    = 8'h00;
    bus.ad_oe     = 1'b0;
    if (state == T1) begin
      bus.ad_out = addr_q[7:0];
      bus.ad_oe  = 1'b1;
    end else if (in_strobe_phase && we_q) begin
      bus.ad_out = wdata_q;
      bus.ad_oe  = 1'b1;
    end
  end

endmodule

// File: tb/tb_bus_cycle_master.sv
// tb/tb_bus_cycle_master.sv - table, directed and randomized checks of bus_cycle_master
module tb_bus_cycle_master;

  localparam int MAX_WAIT = 15;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  logic [7:0] last_rdata;

  bus_cycle_master_if bus ();

  bus_cycle_master #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic       req_ready;
    logic       rsp_valid;
    logic       rsp_err;
    logic       ale;
    logic       rdb;
    logic       wrb;
    logic       iom;
    logic [7:0] a_hi;
    logic       ad_oe;
    logic [7:0] ad_out;
    logic [7:0] rsp_rdata;
  } obs_t;

  typedef struct {
    string       name;
    logic        we;
    logic        io;
    logic [15:0] addr;
    logic [7:0]  wdata;
    int          nwait;
    logic [7:0]  rdval;
    int          exp_lat;
    logic        exp_err;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t tbl[7];

  task automatic check(input string name, input int cyc, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.req_ready = bus.req_ready;
    o.rsp_valid = bus.rsp_valid;
    o.rsp_err   = bus.rsp_err;
    o.ale       = bus.ALE;
    o.rdb       = bus.rdb;
    o.wrb       = bus.wrb;
    o.iom       = bus.IOM;
    o.a_hi      = bus.a_hi;
    o.ad_oe     = bus.ad_oe;
    o.ad_out    = bus.ad_out;
    o.rsp_rdata = bus.rsp_rdata;
    return o;
  endfunction

  // expected outputs j cycles after the accept edge; j=0 means idle
  function automatic obs_t model(input int j, input int tj, input bit tmo, input logic we,
                                 input logic io, input logic [15:0] addr, input logic [7:0] wdata,
                                 input logic [7:0] oldrd, input logic [7:0] newrd);
    obs_t e;
    bit busy;
    bit strobe;
    busy        = (j >= 1) && (j < tj);
    strobe      = (j >= 2) && (j < tj);
    e.req_ready = (j == 0) || (j > tj);
    e.rsp_valid = (j == tj);
    e.rsp_err   = (j == tj) && tmo;
    e.ale       = (j == 1);
    e.rdb       = !(strobe && !we);
    e.wrb       = !(strobe && we);
    e.iom       = busy && io;
    e.a_hi      = busy ? addr[15:8] : 8'h00;
    e.ad_oe     = (j == 1) || (strobe && we);
    e.ad_out    = (j == 1) ? addr[7:0] : wdata;
    e.rsp_rdata = (j >= tj) ? newrd : oldrd;
    return e;
  endfunction

  task automatic check_obs(input string name, input int cyc, input obs_t e);
    obs_t a;
    a = sample();
    if (!e.ad_oe) begin
      e.ad_out = 8'h00;
      a.ad_out = 8'h00;
    end
    check(name, cyc, 64'(a), 64'(e));
  endtask

  task automatic randomize_idle_inputs();
    bus.req       = 1'b0;
    bus.req_we    = 1'($urandom);
    bus.req_io    = 1'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 8'($urandom);
    bus.READY     = 1'($urandom);
    bus.ad_in     = 8'($urandom);
  endtask

  task automatic idle_cycles(input int n);
    obs_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      randomize_idle_inputs();
      e = model(0, 1, 1'b0, 1'b0, 1'b0, 16'h0, 8'h0, last_rdata, last_rdata);
      check_obs("idle", i, e);
    end
  endtask

  // runs one access starting at a negedge in IDLE; ends at the negedge of the first idle cycle
  task automatic run_txn(input logic we, input logic io, input logic [15:0] addr,
                         input logic [7:0] wdata, input int nwait, input logic [7:0] rdval,
                         output int lat, output logic err, output logic [7:0] rd);
    obs_t       e;
    int         tj;
    bit         tmo;
    logic [7:0] newrd;
    tmo   = nwait > MAX_WAIT;
    tj    = tmo ? 3 + MAX_WAIT : 4 + nwait;
    newrd = (!we && !tmo) ? rdval : 8'h00;
    lat   = 0;
    err   = 1'b0;
    rd    = 8'h00;
    bus.req       = 1'b1;
    bus.req_we    = we;
    bus.req_io    = io;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.READY     = 1'($urandom);
    bus.ad_in     = 8'($urandom);
    for (int j = 0; j <= tj + 1; j++) begin
      if (j > 0) begin
        @(negedge clock);
        randomize_idle_inputs();
        if (j < 2) bus.READY = 1'($urandom);
        else if (tmo) bus.READY = 1'b0;
        else if (j < 2 + nwait) bus.READY = 1'b0;
        else if (j == 2 + nwait) bus.READY = 1'b1;
        bus.ad_in = (!tmo && j == tj - 1) ? rdval : 8'($urandom);
      end
      e = model(j, tj, tmo, we, io, addr, wdata, last_rdata, newrd);
      check_obs("cycle", j, e);
      if (bus.rsp_valid === 1'b1 && lat == 0) begin
        lat = j;
        err = bus.rsp_err;
        rd  = bus.rsp_rdata;
      end
    end
    last_rdata = newrd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         lat;
    logic       err;
    logic [7:0] rd;
    obs_t       rexp;

    checks     = 0;
    failures   = 0;
    last_rdata = 8'h00;

    tbl[0] = '{"read_io",      1'b0, 1'b1, 16'h40A5, 8'h00,  0, 8'h3C,  4, 1'b0, 8'h3C};
    tbl[1] = '{"write_mem",    1'b1, 1'b0, 16'h1234, 8'h5A,  0, 8'hEE,  4, 1'b0, 8'h00};
    tbl[2] = '{"read_3wait",   1'b0, 1'b0, 16'h8001, 8'h00,  3, 8'h99,  7, 1'b0, 8'h99};
    tbl[3] = '{"read_timeout", 1'b0, 1'b1, 16'h2233, 8'h00, 99, 8'h77, 18, 1'b1, 8'h00};
    tbl[4] = '{"read_maxwait", 1'b0, 1'b1, 16'hFFFF, 8'h00, 15, 8'hE1, 19, 1'b0, 8'hE1};
    tbl[5] = '{"write_1wait",  1'b1, 1'b1, 16'h00FF, 8'hC3,  1, 8'h44,  5, 1'b0, 8'h00};
    tbl[6] = '{"write_tmo",    1'b1, 1'b0, 16'hBEEF, 8'h81, 16, 8'h55, 18, 1'b1, 8'h00};

    reset = 1'b1;
    bus.req = 1'b0; bus.req_we = 1'b0; bus.req_io = 1'b0;
    bus.req_addr = 16'h0; bus.req_wdata = 8'h0; bus.READY = 1'b1; bus.ad_in = 8'h0;
    repeat (3) @(negedge clock);
    rexp = '{req_ready: 1'b1, rsp_valid: 1'b0, rsp_err: 1'b0, ale: 1'b0, rdb: 1'b1, wrb: 1'b1,
             iom: 1'b0, a_hi: 8'h00, ad_oe: 1'b0, ad_out: 8'h00, rsp_rdata: 8'h00};
    check("reset_state", 0, 64'(sample()), 64'(rexp));
    reset = 1'b0;
    idle_cycles(2);

    // table-driven accesses
    for (int i = 0; i < 7; i++) begin
      run_txn(tbl[i].we, tbl[i].io, tbl[i].addr, tbl[i].wdata, tbl[i].nwait, tbl[i].rdval, lat, err, rd);
      check({"lat_", tbl[i].name}, i, 64'(lat), 64'(tbl[i].exp_lat));
      check({"err_", tbl[i].name}, i, 64'(err), 64'(tbl[i].exp_err));
      check({"rd_", tbl[i].name}, i, 64'(rd), 64'(tbl[i].exp_rd));
      idle_cycles(1);
    end

    // back-to-back: req held high, read then write
    @(negedge clock);
    bus.req = 1'b1; bus.req_we = 1'b0; bus.req_io = 1'b1;
    bus.req_addr = 16'hA1B2; bus.req_wdata = 8'h00; bus.READY = 1'b1; bus.ad_in = 8'h00;
    check("b2b_ready0", 0, 64'(bus.req_ready), 64'(1));
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (c == 1) begin
        bus.req_we = 1'b1; bus.req_io = 1'b0; bus.req_addr = 16'h5C6D; bus.req_wdata = 8'h7E;
      end
      if (c == 6) bus.req = 1'b0;
      bus.ad_in = (c == 3) ? 8'h11 : 8'($urandom);
      check("b2b_ready_ale_rsp", c, 64'({bus.req_ready, bus.ALE, bus.rsp_valid}),
            64'({(c == 5) || (c >= 10), (c == 1) || (c == 6), (c == 4) || (c == 9)}));
      if (c == 4) check("b2b_rdata", c, 64'(bus.rsp_rdata), 64'(8'h11));
      if (c == 6) check("b2b_ale_addr", c, 64'(bus.ad_out), 64'(8'h6D));
      if (c == 7) check("b2b_wr_strobes", c, 64'({bus.wrb, bus.rdb, bus.ad_out}), 64'({1'b0, 1'b1, 8'h7E}));
    end
    last_rdata = 8'h00;

    // reset during TW of a write
    @(negedge clock);
    bus.req = 1'b1; bus.req_we = 1'b1; bus.req_io = 1'b1;
    bus.req_addr = 16'h3344; bus.req_wdata = 8'hA7; bus.READY = 1'b0;
    @(negedge clock);
    bus.req = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("rst_pre_wrb", 3, 64'(bus.wrb), 64'(0));
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    bus.READY = 1'b1;
    check("rst_abort", 4, 64'(sample()), 64'(rexp));
    last_rdata = 8'h00;
    idle_cycles(6);

    // randomized accesses against the cycle-index model
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic        io;
      logic [15:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  rdval;
      int          nwait;
      bit          tmo;
      we    = 1'($urandom);
      io    = 1'($urandom);
      addr  = 16'($urandom);
      wdata = 8'($urandom);
      rdval = 8'($urandom);
      nwait = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 17));
      tmo   = nwait > MAX_WAIT;
      run_txn(we, io, addr, wdata, nwait, rdval, lat, err, rd);
      check("rnd_lat", n, 64'(lat), 64'(tmo ? 3 + MAX_WAIT : 4 + nwait));
      check("rnd_err", n, 64'(err), 64'(tmo));
      check("rnd_rd", n, 64'(rd), 64'((!we && !tmo) ? rdval : 8'h00));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
